// File: rtl/cmul_seq_pkg.sv
// ============================================================================
// Module : cmul_seq_pkg
// Brief  : Shared types and helpers for the sequenced complex multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cmul_seq_pkg;

    localparam int unsigned c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_M0   = 3'd1,
        ST_M1   = 3'd2,
        ST_M2   = 3'd3,
        ST_M3   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // One guard bit above the 2W product absorbs the add/sub of two products.
    function automatic int unsigned out_width(input int unsigned w);
        return 2 * w + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmul_seq_smul.sv
// ============================================================================
// Module : cmul_seq_smul
// Brief  : Combinational signed W x W -> 2W multiplier (the shared resource).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cmul_seq_smul #(
    parameter int W = 8
) (
    input  logic signed [W-1:0]   i_x,
    input  logic signed [W-1:0]   i_y,
    output logic signed [2*W-1:0] o_p
);

    assign o_p = i_x * i_y;

endmodule

`default_nettype wire

// File: rtl/cmul_seq.sv
// ============================================================================
// Module : cmul_seq
// Brief  : Complex multiplier p = a*b sequenced over one shared real multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cmul_seq
    import cmul_seq_pkg::*;
#(
    parameter  int W  = 8,
    localparam int OW = int'(out_width(W))
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*W-1:0]  a,
    input  logic [2*W-1:0]  b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*OW-1:0] p,
    output logic            busy
);

    state_t                r_state;
    logic signed [W-1:0]   r_ar;
    logic signed [W-1:0]   r_ai;
    logic signed [W-1:0]   r_br;
    logic signed [W-1:0]   r_bi;
    logic signed [OW-1:0]  r_acc_re;
    logic signed [OW-1:0]  r_acc_im;
    logic [2*OW-1:0]       r_p;
    logic                  r_out_valid;
    logic                  r_busy;

    logic signed [W-1:0]   w_mx;
    logic signed [W-1:0]   w_my;
    logic signed [2*W-1:0] w_prod;
    logic signed [OW-1:0]  w_prod_ext;
    logic signed [OW-1:0]  w_im_sum;

    // Operand pairing per state: ar*br, ai*bi, ar*bi, ai*br.
    always_comb begin
        w_mx = r_ar;
        w_my = r_br;
        case (r_state)
            ST_M1:   begin w_mx = r_ai; w_my = r_bi; end
            ST_M2:   begin w_mx = r_ar; w_my = r_bi; end
            ST_M3:   begin w_mx = r_ai; w_my = r_br; end
            default: begin w_mx = r_ar; w_my = r_br; end
        endcase
    end

    cmul_seq_smul #(
        .W (W)
    ) u_smul (
        .i_x (w_mx),
        .i_y (w_my),
        .o_p (w_prod)
    );

    assign w_prod_ext = {{(OW-2*W){w_prod[2*W-1]}}, w_prod};
    assign w_im_sum   = r_acc_im + w_prod_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ar        <= '0;
            r_ai        <= '0;
            r_br        <= '0;
            r_bi        <= '0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_p         <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_ar    <= a[2*W-1:W];
                        r_ai    <= a[W-1:0];
                        r_br    <= b[2*W-1:W];
                        r_bi    <= b[W-1:0];
                        r_busy  <= 1'b1;
                        r_state <= ST_M0;
                    end
                end
                ST_M0: begin
                    r_acc_re <= w_prod_ext;
                    r_state  <= ST_M1;
                end
                ST_M1: begin
                    r_acc_re <= r_acc_re - w_prod_ext;
                    r_state  <= ST_M2;
                end
                ST_M2: begin
                    r_acc_im <= w_prod_ext;
                    r_state  <= ST_M3;
                end
                ST_M3: begin
                    r_acc_im    <= w_im_sum;
                    r_p         <= {r_acc_re, w_im_sum};
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign p         = r_p;

endmodule

`default_nettype wire

// File: tb/tb_cmul_seq.sv
// ============================================================================
// Module : tb_cmul_seq
// Brief  : Directed self-checking bench for cmul_seq with W=8.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cmul_seq;

    localparam int c_W  = 8;
    localparam int c_OW = 2 * c_W + 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2*c_W-1:0]  a;
    logic [2*c_W-1:0]  b;
    logic              out_valid;
    logic              out_ready;
    logic [2*c_OW-1:0] p;
    logic              busy;

    int n_checks;
    int n_fail;
    int cyc;

    cmul_seq #(
        .W (c_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic chk_p(input string tag, input int er, input int ei);
        logic [c_OW-1:0] w_er;
        logic [c_OW-1:0] w_ei;
        w_er = er[c_OW-1:0];
        w_ei = ei[c_OW-1:0];
        chk({tag, ".re"}, 32'(p[2*c_OW-1:c_OW]), 32'(w_er));
        chk({tag, ".im"}, 32'(p[c_OW-1:0]), 32'(w_ei));
    endtask

    task automatic drive_ops(input int ar, input int ai, input int br, input int bi);
        a = {ar[c_W-1:0], ai[c_W-1:0]};
        b = {br[c_W-1:0], bi[c_W-1:0]};
    endtask

    // Returns at the negedge where out_valid is first seen (state DONE).
    task automatic run_op(input string tag, input int ar, input int ai, input int br,
                          input int bi, input int er, input int ei);
        int n;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        drive_ops(ar, ai, br, bi);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        // Scramble operands after acceptance; result must not depend on them.
        drive_ops(37, -91, -5, 113);
        n = 0;
        while (!out_valid && n < 12) begin
            @(negedge clk);
            n++;
            if (!out_valid) chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        end
        chk({tag, ".latency"}, 32'(n), 32'd4);
        chk_p(tag, er, ei);
    endtask

    initial begin
        int t0;
        int t1;
        int n;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk_p("rst.p", 0, 0);
        rst = 1'b0;

        run_op("op1", -10, 5, 3, -8, 10, 95);
        @(negedge clk);
        chk("op1.out_valid_fall", 32'(out_valid), 32'd0);
        chk("op1.in_ready_back", 32'(in_ready), 32'd1);
        chk_p("op1.p_retained", 10, 95);

        // Back-to-back with in_valid held high; operands switch after first accept.
        drive_ops(6, 3, 2, -6);
        in_valid = 1'b1;
        @(negedge clk);
        chk("b2b.busy0", 32'(busy), 32'd1);
        t0 = cyc;
        drive_ops(2, 8, 0, 2);
        n = 0;
        while (!out_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("b2b.latency0", 32'(n), 32'd4);
        chk_p("b2b.op0", 30, -30);
        n = 0;
        while (!busy && n < 12) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        in_valid = 1'b0;
        chk("b2b.interval", 32'(t1 - t0), 32'd6);
        n = 0;
        while (!out_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("b2b.latency1", 32'(n), 32'd4);
        chk_p("b2b.op1", -16, 4);

        // Consumer stalls for 10 cycles; a competing request must not be taken.
        @(negedge clk);
        out_ready = 1'b0;
        run_op("stall", 4, 1, -2, -7, -1, -30);
        drive_ops(9, 9, 9, 9);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall.out_valid", 32'(out_valid), 32'd1);
            chk("stall.in_ready", 32'(in_ready), 32'd0);
            chk_p("stall.p", -1, -30);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall.release", 32'(out_valid), 32'd0);
        chk("stall.busy", 32'(busy), 32'd0);

        run_op("ext1", -128, -128, -128, 127, 32640, 128);
        run_op("ext2", -128, -128, -128, -128, 0, 32768);

        // Reset in M2 aborts the operation and clears p.
        @(negedge clk);
        drive_ops(3, 4, 5, 6);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        chk_p("mrst.p", 0, 0);
        run_op("post_rst", 1, 1, 1, -1, 2, 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
